hdmi_i2c_init_sequencer: RTL

Walks a register-initialisation table and issues one I2C register write per entry through the byte-level I2C master's host handshake. Configures the HDMI transmitter/companion chips after reset. Sits between a synchronous table ROM and the I2C master. Also handles inter-write delays, NACK retries, transaction timeout, and done/error reporting.

---
 rtl/hdmi_i2c_init_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/hdmi_i2c_init_sequencer.sv
// Walks a register-init table and issues one I2C write per entry through the
// byte-level master's enable/ready handshake, with delays, NACK retries and timeout.
module hdmi_i2c_init_sequencer #(
  parameter int NUM_ENTRIES = 32,
  parameter int DELAY_UNIT  = 1000,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT     = 65535,
  parameter bit AUTO_START  = 1'b1,
  localparam int IW = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [IW-1:0] tbl_addr,
  input  logic [23:0]   tbl_data,
  output logic [6:0]    i2c_addr,
  output logic [15:0]   i2c_data,
  output logic          i2c_rw,
  output logic          i2c_enable,
  input  logic          i2c_ready,
  input  logic          i2c_nack,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [IW-1:0] err_index
);

  localparam int DW = $clog2(255 * DELAY_UNIT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IW-1:0] LAST_INDEX = IW'(NUM_ENTRIES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [15:0]   TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [23:0]   END_MARKER = 24'hFF_FFFF;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ROM_WAIT, S_DECODE, S_ISSUE,
    S_WAIT_ACCEPT, S_WAIT_DONE, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t        state;
  logic [IW-1:0] index;
  logic [RW-1:0] retry;
  logic [15:0]   timer;
  logic [DW-1:0] delay_cnt;
  logic          auto_pend;

  // Only writes are ever issued.
  assign i2c_rw = 1'b0;

  // NOTE: all state and outputs update with non-blocking assignments so every
  // branch below reads the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      index      <= '0;
      retry      <= '0;
      timer      <= '0;
      delay_cnt  <= '0;
      auto_pend  <= AUTO_START;
      tbl_addr   <= '0;
      i2c_addr   <= '0;
      i2c_data   <= '0;
      i2c_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_index  <= '0;
    end else begin
      auto_pend <= 1'b0;
      // NOTE: the timer clears by default; only the "stay in wait state"
      // branches override it, so any state change restarts it from zero.
      timer     <= '0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start || auto_pend) begin
            index     <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          tbl_addr <= index;
          state    <= S_ROM_WAIT;
        end
        S_ROM_WAIT: state <= S_DECODE;
        S_DECODE: begin
          if (tbl_data == END_MARKER) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tbl_data[23]) begin
            delay_cnt <= DW'(tbl_data[7:0]) * DW'(DELAY_UNIT);
            state     <= (tbl_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
          end else begin
            i2c_addr <= tbl_data[22:16];
            i2c_data <= tbl_data[15:0];
            retry    <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          i2c_enable <= 1'b1;
          state      <= S_WAIT_ACCEPT;
        end
        S_WAIT_ACCEPT: begin
          if (!i2c_ready) begin
            i2c_enable <= 1'b0;
            state      <= S_WAIT_DONE;
          end else if (timer == TIMER_LAST) begin
            i2c_enable <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            err_index  <= index;
            state      <= S_ERROR;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_WAIT_DONE: begin
          // A completion seen in the same cycle as the timeout takes priority.
          if (i2c_ready) begin
            if (!i2c_nack) begin
              state <= S_NEXT;
            end else if (retry != RETRY_MAX) begin
              retry <= retry + RW'(1);
              state <= S_ISSUE;
            end else begin
              busy      <= 1'b0;
              error     <= 1'b1;
              err_index <= index;
              state     <= S_ERROR;
            end
          end else if (timer == TIMER_LAST) begin
            busy      <= 1'b0;
            error     <= 1'b1;
            err_index <= index;
            state     <= S_ERROR;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_DELAY: begin
          if (delay_cnt <= DW'(1)) begin
            delay_cnt <= '0;
            state     <= S_NEXT;
          end else begin
            delay_cnt <= delay_cnt - DW'(1);
          end
        end
        S_NEXT: begin
          if (index == LAST_INDEX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            index <= index + IW'(1);
            state <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
